// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file slice.
// Build option: REGFILE_WR_BYPASS_EN (see regfile_mp.sv).
package regfile_pkg;

  // Default geometry of the register file.
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_NUM_WR   = 1;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  // Address and data types for the default geometry.
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // Register 0 is hardwired to zero: never written, never busy.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue,
// cleared by retiring writes, with one lookup per read port.
// Build option: none (REGFILE_WR_BYPASS_EN does not affect busy lookup).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [NUM_WR-1:0]        clr_en,
  input  logic [NUM_WR*ADDR_W-1:0] clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Next busy vector: retiring writes clear first, then a new issue sets,
  // so a new producer supersedes the one retiring on the same edge.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (clr_en[w] && (clr_addr[w*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
        busy_nxt[clr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (issue_en && (issue_addr != ZERO_ADDR)) begin
      busy_nxt[issue_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy register; reset clears every bit immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Per-port lookup of the registered busy bit (no bypass of retiring writes).
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with pending-write scoreboard.
// Build option: define REGFILE_WR_BYPASS_EN to forward same-cycle write
// data to matching read ports (higher write port wins); otherwise reads
// return storage contents only and new values appear after the edge.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        RdBusy,
  input  logic [NUM_WR-1:0]        WrEn,
  input  logic [NUM_WR*ADDR_W-1:0] WrAddr,
  input  logic [NUM_WR*DATA_W-1:0] WrData,
  input  logic                     IssueEn,
  input  logic [ADDR_W-1:0]        IssueAddr
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs    [NUM_REGS];
  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_data [NUM_RD];
  logic [ADDR_W-1:0] wr_addr [NUM_WR];
  logic [DATA_W-1:0] wr_data [NUM_WR];

  // Split the flat port buses into per-port fields.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr[k] = RdAddr[k*ADDR_W +: ADDR_W];
    end
    for (int w = 0; w < NUM_WR; w++) begin
      wr_addr[w] = WrAddr[w*ADDR_W +: ADDR_W];
      wr_data[w] = WrData[w*DATA_W +: DATA_W];
    end
  end

  // Storage update; ports are applied in ascending order so the highest
  // numbered port wins on an address collision. Register 0 is never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (WrEn[w] && (wr_addr[w] != ZERO_ADDR)) begin
          regs[wr_addr[w]] <= wr_data[w];
        end
      end
    end
  end

  // Read mux: storage contents, zero for register 0, optional write bypass.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k] = '0;
      if (rd_addr[k] != ZERO_ADDR) begin
        rd_data[k] = regs[rd_addr[k]];
`ifdef REGFILE_WR_BYPASS_EN
        // Writes are ignored during reset, so nothing is forwarded then.
        if (!reset) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (WrEn[w] && (wr_addr[w] == rd_addr[k])) begin
              rd_data[k] = wr_data[w];
            end
          end
        end
`endif
      end
    end
  end

  // Pack read data back onto the flat output bus.
  always_comb begin
    RdData = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      RdData[k*DATA_W +: DATA_W] = rd_data[k];
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (IssueEn),
    .issue_addr (IssueAddr),
    .clr_en     (WrEn),
    .clr_addr   (WrAddr),
    .rd_addr    (RdAddr),
    .rd_busy    (RdBusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (4 read, 2 write ports).
`timescale 1ns/1ps
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NRD = 4;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NRD*AW-1:0] RdAddr;
  logic [NRD*DW-1:0] RdData;
  logic [NRD-1:0]    RdBusy;
  logic [NWR-1:0]    WrEn;
  logic [NWR*AW-1:0] WrAddr;
  logic [NWR*DW-1:0] WrData;
  logic              IssueEn;
  logic [AW-1:0]     IssueAddr;

  // Bench-side per-port stimulus.
  logic [AW-1:0] rd_a [NRD];
  logic          wr_en [NWR];
  logic [AW-1:0] wr_a [NWR];
  logic [DW-1:0] wr_d [NWR];

  // Behavioural model state.
  logic [DW-1:0] mregs [NR];
  logic          mbusy [NR];

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NRD; k++) RdAddr[k*AW +: AW] = rd_a[k];
    for (int w = 0; w < NWR; w++) begin
      WrEn[w] = wr_en[w];
      WrAddr[w*AW +: AW] = wr_a[w];
      WrData[w*DW +: DW] = wr_d[w];
    end
  end

  regfile_mp #(
    .DATA_W (DW), .NUM_REGS (NR), .ADDR_W (AW), .NUM_RD (NRD), .NUM_WR (NWR)
  ) dut (
    .clk (clk), .reset (reset),
    .RdAddr (RdAddr), .RdData (RdData), .RdBusy (RdBusy),
    .WrEn (WrEn), .WrAddr (WrAddr), .WrData (WrData),
    .IssueEn (IssueEn), .IssueAddr (IssueAddr)
  );

  task automatic check(input string name, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, idx, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_data(input int k);
    logic [DW-1:0] d;
    if (reset || rd_a[k] == 0) return '0;
    d = mregs[rd_a[k]];
`ifdef REGFILE_WR_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wr_a[w] == rd_a[k]) d = wr_d[w];
`endif
    return d;
  endfunction

  function automatic logic model_busy(input int k);
    if (reset || rd_a[k] == 0) return 1'b0;
    return mbusy[rd_a[k]];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      mregs[r] = '0;
      mbusy[r] = 1'b0;
    end
  endtask

  // Apply one clock edge of the architectural rules.
  task automatic model_edge();
    logic [DW-1:0] new_val [NR];
    logic          written [NR];
    if (reset) begin
      model_clear();
      return;
    end
    for (int r = 0; r < NR; r++) written[r] = 1'b0;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wr_a[w] != 0) begin
        written[wr_a[w]] = 1'b1;
        new_val[wr_a[w]] = wr_d[w];
      end
    for (int r = 1; r < NR; r++)
      if (written[r]) begin
        mregs[r] = new_val[r];
        mbusy[r] = 1'b0;
      end
    if (IssueEn && IssueAddr != 0) mbusy[IssueAddr] = 1'b1;
  endtask

  task automatic compare_all();
    for (int k = 0; k < NRD; k++) begin
      check("rd_data", k, RdData[k*DW +: DW], model_data(k));
      check("rd_busy", k, {31'd0, RdBusy[k]}, {31'd0, model_busy(k)});
    end
  endtask

  // One clock: compare at the falling edge, advance model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < NRD; k++) rd_a[k] = '0;
    for (int w = 0; w < NWR; w++) begin
      wr_en[w] = 1'b0; wr_a[w] = '0; wr_d[w] = '0;
    end
    IssueEn = 1'b0;
    IssueAddr = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    model_clear();
    rd_a[0] = 5'd5;
    cycle();
    cycle();
    reset = 1'b0;

    // Write r5 and issue r5 on the same edge: data lands, busy set wins.
    wr_en[0] = 1'b1; wr_a[0] = 5'd5; wr_d[0] = 32'hDEADBEEF;
    IssueEn = 1'b1; IssueAddr = 5'd5;
    cycle();
    idle();
    rd_a[0] = 5'd5;
    #2;
    check("lit_r5_data", 0, RdData[0 +: DW], 32'hDEADBEEF);
    check("lit_r5_busy", 0, {31'd0, RdBusy[0]}, 32'd1);
    // Mid-cycle reset pulse takes effect before the next edge.
    #1 reset = 1'b1;
    #2;
    check("lit_rst_data", 0, RdData[0 +: DW], 32'd0);
    check("lit_rst_busy", 0, {31'd0, RdBusy[0]}, 32'd0);
    #2 reset = 1'b0;
    model_clear();
    cycle();

    // Zero register: write and issue r0 have no effect.
    wr_en[0] = 1'b1; wr_a[0] = 5'd0; wr_d[0] = 32'h1234;
    IssueEn = 1'b1; IssueAddr = 5'd0;
    cycle();
    idle();
    #2;
    check("lit_r0_data", 0, RdData[0 +: DW], 32'd0);
    check("lit_r0_busy", 0, {31'd0, RdBusy[0]}, 32'd0);
    cycle();

    // Write port priority: port 1 wins on r7.
    wr_en[0] = 1'b1; wr_a[0] = 5'd7; wr_d[0] = 32'hA;
    wr_en[1] = 1'b1; wr_a[1] = 5'd7; wr_d[1] = 32'hB;
    rd_a[1] = 5'd7;
    cycle();
    idle();
    rd_a[1] = 5'd7;
    #2;
    check("lit_r7_prio", 1, RdData[DW +: DW], 32'hB);
    cycle();

    // Bypass: r3 holds 0x11, then write 0x55 and read in the same cycle.
    wr_en[0] = 1'b1; wr_a[0] = 5'd3; wr_d[0] = 32'h11;
    cycle();
    wr_d[0] = 32'h55;
    rd_a[2] = 5'd3;
    #2;
`ifdef REGFILE_WR_BYPASS_EN
    check("lit_r3_same", 2, RdData[2*DW +: DW], 32'h55);
`else
    check("lit_r3_same", 2, RdData[2*DW +: DW], 32'h11);
`endif
    cycle();
    idle();
    rd_a[2] = 5'd3;
    #2;
    check("lit_r3_next", 2, RdData[2*DW +: DW], 32'h55);
    cycle();

    // Scoreboard on r9: issue, retire, then issue and retire together.
    IssueEn = 1'b1; IssueAddr = 5'd9;
    rd_a[3] = 5'd9;
    cycle();
    idle();
    rd_a[3] = 5'd9;
    #2;
    check("lit_r9_issue", 3, {31'd0, RdBusy[3]}, 32'd1);
    wr_en[1] = 1'b1; wr_a[1] = 5'd9; wr_d[1] = 32'h99;
    #1;
    check("lit_r9_nobyp", 3, {31'd0, RdBusy[3]}, 32'd1);
    cycle();
    idle();
    rd_a[3] = 5'd9;
    #2;
    check("lit_r9_retire", 3, {31'd0, RdBusy[3]}, 32'd0);
    wr_en[0] = 1'b1; wr_a[0] = 5'd9; wr_d[0] = 32'h77;
    IssueEn = 1'b1; IssueAddr = 5'd9;
    cycle();
    idle();
    rd_a[3] = 5'd9;
    #2;
    check("lit_r9_both_busy", 3, {31'd0, RdBusy[3]}, 32'd1);
    check("lit_r9_both_data", 3, RdData[3*DW +: DW], 32'h77);
    cycle();

    // Multi-read after writing r1 = 1 and r2 = 2.
    wr_en[0] = 1'b1; wr_a[0] = 5'd1; wr_d[0] = 32'd1;
    wr_en[1] = 1'b1; wr_a[1] = 5'd2; wr_d[1] = 32'd2;
    cycle();
    idle();
    rd_a[0] = 5'd1; rd_a[1] = 5'd2; rd_a[2] = 5'd1; rd_a[3] = 5'd0;
    #2;
    check("lit_multi", 0, RdData[0*DW +: DW], 32'd1);
    check("lit_multi", 1, RdData[1*DW +: DW], 32'd2);
    check("lit_multi", 2, RdData[2*DW +: DW], 32'd1);
    check("lit_multi", 3, RdData[3*DW +: DW], 32'd0);
    cycle();

    // Earlier values persist: r5 was cleared by reset, r7 and r9 remain.
    rd_a[0] = 5'd5; rd_a[1] = 5'd7; rd_a[2] = 5'd9; rd_a[3] = 5'd3;
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
